// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: walks a byte-wide, ready/stall instruction memory
// one beat at a time and assembles icode/ifun, rA/rB, valC and valP for decode.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing byte reads, k beats accepted so far
// DONE    | fields valid, done pulse
// HALTED  | halt instruction fetched, frozen until reset
module fetch_sequencer #(
  parameter int IMEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        done,
  output logic        busy,
  output logic        halt,
  output logic        instr_valid,
  output logic        imem_error
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_HALTED} state_t;

  localparam logic [63:0] LAST_ADDR = 64'(IMEM_SIZE - 1);

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  len_q, len_d;
  logic        mem_rd_q, mem_rd_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic        done_q, done_d, busy_q, busy_d, halt_q, halt_d;
  logic        iv_q, iv_d, err_q, err_d;

  logic [3:0]  byte_len;
  logic [3:0]  next_k;
  logic [63:0] cur_addr, next_addr;
  logic [3:0]  const_idx;
  logic        const_wr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    k_d        = k_q;
    len_d      = len_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    icode_d    = icode_q;
    ifun_d     = ifun_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    valc_d     = valc_q;
    valp_d     = valp_q;
    halt_d     = halt_q;
    iv_d       = iv_q;
    err_d      = err_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    byte_len   = len_q;
    next_k     = k_q + 4'd1;
    cur_addr   = pc_q + {60'd0, k_q};
    next_addr  = pc_q + {60'd0, next_k};
    const_idx  = 4'd0;
    const_wr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = pc_in;
          k_d        = 4'd0;
          len_d      = 4'd0;
          icode_d    = 4'h0;
          ifun_d     = 4'h0;
          ra_d       = 4'hF;
          rb_d       = 4'hF;
          valc_d     = 64'd0;
          valp_d     = 64'd0;
          iv_d       = 1'b0;
          err_d      = 1'b0;
          mem_addr_d = pc_in;
          mem_rd_d   = (pc_in <= LAST_ADDR);
          busy_d     = 1'b1;
        end
      end

      S_FETCH: begin
        busy_d = 1'b1;
        if (mem_rd_q) begin
          if (mem_ready) begin
            // len_q is still 0 while byte 0 is in flight, so the field decodes below stay inert
            if (k_q == 4'd0) begin
              icode_d  = mem_rdata[7:4];
              ifun_d   = mem_rdata[3:0];
              iv_d     = (mem_rdata[7:4] <= 4'hB);
              byte_len = instr_len(mem_rdata[7:4]);
              len_d    = byte_len;
            end else if (k_q == 4'd1 && (len_q == 4'd2 || len_q == 4'd10)) begin
              ra_d = mem_rdata[7:4];
              rb_d = mem_rdata[3:0];
            end
            if (len_q == 4'd10 && k_q >= 4'd2) begin
              const_idx = k_q - 4'd2;
              const_wr  = 1'b1;
            end else if (len_q == 4'd9 && k_q >= 4'd1) begin
              const_idx = k_q - 4'd1;
              const_wr  = 1'b1;
            end
            if (const_wr) begin
              for (int i = 0; i < 8; i++) begin
                if (4'(i) == const_idx) valc_d[8*i +: 8] = mem_rdata;
              end
            end
            k_d        = next_k;
            mem_addr_d = next_addr;
            mem_rd_d   = (next_k != byte_len) && (next_addr <= LAST_ADDR);
          end
        end else begin
          // No read pending: either all L bytes are in, or the next byte is out of range
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valp_d  = cur_addr;
          err_d   = !(k_q != 4'd0 && k_q == len_q);
        end
      end

      S_DONE: begin
        if (icode_q == 4'h0 && iv_q && !err_q) begin
          halt_d  = 1'b1;
          state_d = S_HALTED;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= 64'd0;
      k_q        <= 4'd0;
      len_q      <= 4'd0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 64'd0;
      icode_q    <= 4'h0;
      ifun_q     <= 4'h0;
      ra_q       <= 4'hF;
      rb_q       <= 4'hF;
      valc_q     <= 64'd0;
      valp_q     <= 64'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      halt_q     <= 1'b0;
      iv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      k_q        <= k_d;
      len_q      <= len_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      icode_q    <= icode_d;
      ifun_q     <= ifun_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      valc_q     <= valc_d;
      valp_q     <= valp_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      halt_q     <= halt_d;
      iv_q       <= iv_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign halt        = halt_q;
  assign instr_valid = iv_q;
  assign imem_error  = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a byte-array memory model, a reference decoder
// working from the instruction-length rules, and monitors for beats and done pulses.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_rd, mem_ready;
  logic [63:0] pc_in, mem_addr, valC, valP;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic        done, busy, halt, instr_valid, imem_error;

  fetch_sequencer #(.IMEM_SIZE(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .done(done), .busy(busy), .halt(halt), .instr_valid(instr_valid), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:127];
  assign mem_rdata = (mem_addr < 64'd128) ? mem[mem_addr[6:0]] : 8'h00;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        iv, err;
    int          nbeats;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] addr_q[$];

  int total = 0, bad = 0;
  int cyc = 0, st_cyc = 0, done_cnt = 0;
  int beat_idx = 0, stalls = 0, stall_beat = -1, stall_len = 0, stall_cnt = 0;
  bit rand_ready = 0;
  logic [63:0] stall_exp_addr = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected (t=%0t)", name, $time);
  endtask

  // Reference: gather up to L in-range bytes, then slice fields from them.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    logic [7:0] b [10];
    int len, n, off;
    e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 64'd0; e.iv = 1'b0;
    len = 1;
    n = 0;
    if (pc <= 64'd127) begin
      case (mem[pc[6:0]][7:4])
        4'h0, 4'h1, 4'h9:       len = 1;
        4'h2, 4'h6, 4'hA, 4'hB: len = 2;
        4'h3, 4'h4, 4'h5:       len = 10;
        4'h7, 4'h8:             len = 9;
        default:                len = 1;
      endcase
    end
    for (int j = 0; j < len; j++) begin
      if (pc + 64'(j) > 64'd127) break;
      b[j] = mem[7'(pc + 64'(j))];
      n++;
    end
    if (n > 0) begin
      e.icode = b[0][7:4];
      e.ifun  = b[0][3:0];
      e.iv    = (b[0][7:4] <= 4'hB);
    end
    if ((len == 2 || len == 10) && n > 1) begin
      e.ra = b[1][7:4];
      e.rb = b[1][3:0];
    end
    off = (len == 10) ? 2 : (len == 9) ? 1 : 0;
    if (off != 0)
      for (int j = off; j < n; j++) e.valc[8*(j-off) +: 8] = b[j];
    e.err    = (n < len);
    e.valp   = pc + 64'(n);
    e.nbeats = n;
    return e;
  endfunction

  // Memory ready driver plus beat monitor.
  always @(negedge clk) begin
    if (mem_rd && beat_idx == stall_beat && stall_cnt < stall_len) begin
      mem_ready = 1'b0;
      stall_cnt++;
      chk("stall_addr_hold", mem_addr, stall_exp_addr);
    end else if (rand_ready) begin
      mem_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mem_ready = 1'b1;
    end
    if (rst_n && mem_rd && !mem_ready) stalls++;
    if (rst_n && mem_rd && mem_ready) begin
      if (addr_q.size() == 0) fail_evt("unexpected_beat");
      else chk("beat_addr", mem_addr, addr_q.pop_front());
      beat_idx++;
    end
  end

  // Done monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        fail_evt("unexpected_done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("icode", 64'(icode), 64'(e.icode));
        chk("ifun", 64'(ifun), 64'(e.ifun));
        chk("rA", 64'(rA), 64'(e.ra));
        chk("rB", 64'(rB), 64'(e.rb));
        chk("valC", valC, e.valc);
        chk("valP", valP, e.valp);
        chk("instr_valid", 64'(instr_valid), 64'(e.iv));
        chk("imem_error", 64'(imem_error), 64'(e.err));
        chk("beats_left", 64'(addr_q.size()), 64'd0);
        chk("latency", 64'(cyc - st_cyc), 64'(e.nbeats + 2 + stalls));
        chk("busy_in_done", 64'(busy), 64'd0);
      end
      done_cnt++;
    end
  end

  task automatic issue(input logic [63:0] pc);
    exp_t e;
    @(negedge clk);
    e = model(pc);
    exp_q.push_back(e);
    for (int j = 0; j < e.nbeats; j++) addr_q.push_back(pc + 64'(j));
    beat_idx = 0;
    stalls = 0;
    stall_cnt = 0;
    stall_exp_addr = pc + 64'(stall_beat);
    start = 1'b1;
    pc_in = pc;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] pc, input bit rr, input int sb, input int sl);
    int dc;
    bit got;
    rand_ready = rr;
    stall_beat = sb;
    stall_len = sl;
    dc = done_cnt;
    got = 0;
    issue(pc);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != dc) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_evt("done_timeout");
    stall_beat = -1;
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_ifun", 64'(ifun), 64'd0);
    chk("rst_rA", 64'(rA), 64'hF);
    chk("rst_rB", 64'(rB), 64'hF);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_flags", {59'd0, done, busy, halt, instr_valid, imem_error}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pc_in = 64'd0;
    mem_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    #23;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // nop at 0
    mem[0] = 8'h10;
    fetch(64'd0, 0, -1, 0);
    chk("nop_valP", valP, 64'd1);
    chk("nop_icode", 64'(icode), 64'd1);

    // irmovq $10,%rbx at 4
    begin
      logic [7:0] irm [10];
      irm = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) mem[4+i] = irm[i];
    end
    fetch(64'd4, 0, -1, 0);
    chk("irmovq_rA", 64'(rA), 64'hF);
    chk("irmovq_rB", 64'(rB), 64'h3);
    chk("irmovq_valC", valC, 64'hA);
    chk("irmovq_valP", valP, 64'd14);

    // call 0x20 with a 3-cycle stall on beat 4
    mem[0] = 8'h80;
    mem[1] = 8'h20;
    for (int i = 2; i < 9; i++) mem[i] = 8'h00;
    fetch(64'd0, 0, 4, 3);
    chk("call_valC", valC, 64'h20);
    chk("call_valP", valP, 64'd9);
    chk("call_stalls", 64'(stall_cnt), 64'd3);

    // 10-byte instruction running off the end of memory
    mem[120] = 8'h50;
    fetch(64'd120, 0, -1, 0);
    chk("oor_err", 64'(imem_error), 64'd1);
    chk("oor_valP", valP, 64'd128);

    // invalid icode
    mem[0] = 8'hC0;
    fetch(64'd0, 0, -1, 0);
    chk("inv_valid", 64'(instr_valid), 64'd0);
    chk("inv_valP", valP, 64'd1);

    // start address already out of range
    fetch(64'd200, 0, -1, 0);
    chk("start_oor_err", 64'(imem_error), 64'd1);

    // randomized fetches with random ready
    for (int t = 0; t < 40; t++) begin
      logic [63:0] pc;
      for (int i = 0; i < 4; i++) mem[$urandom_range(0, 127)] = 8'($urandom);
      pc = 64'($urandom_range(0, 131));
      if (pc < 64'd128 && mem[pc[6:0]][7:4] == 4'h0) mem[pc[6:0]] = mem[pc[6:0]] | 8'h10;
      fetch(pc, 1, -1, 0);
    end
    rand_ready = 0;

    // reset in the middle of a 10-byte fetch
    mem[0] = 8'h30;
    begin
      int w;
      stall_beat = -1;
      @(negedge clk);
      for (int j = 0; j < 10; j++) addr_q.push_back(64'(j));
      beat_idx = 0;
      start = 1'b1;
      pc_in = 64'd0;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (beat_idx < 5 && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("mid_reset_reached", 64'(beat_idx >= 5), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      exp_q.delete();
      addr_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end
    fetch(64'd0, 0, -1, 0);
    chk("post_reset_icode", 64'(icode), 64'h3);

    // halt, then a later start is ignored
    mem[50] = 8'h00;
    fetch(64'd50, 0, -1, 0);
    @(negedge clk);
    chk("halt_set", 64'(halt), 64'd1);
    start = 1'b1;
    pc_in = 64'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halted_no_rd", 64'(mem_rd), 64'd0);
    end
    chk("halt_sticky", 64'(halt), 64'd1);
    chk("halted_not_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch controller for the Y86-64 core. It sequences a single-port, byte-wide instruction memory one byte per accepted beat, assembles icode/ifun, rA/rB, valC and valP, and presents the decoded fields to decode with a one-cycle `done` pulse. It replaces the wide, all-bytes-at-once combinational read of fetch when instruction memory sits behind a ready/stall interface.

## Interface
- `IMEM_SIZE`, 128: instruction memory size in bytes; valid addresses are 0..IMEM_SIZE-1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a fetch at `pc_in`; sampled only in IDLE.
- `pc_in` input 64: instruction address.
- `mem_rd` output 1: byte read request.
- `mem_addr` output 64: byte address.
- `mem_rdata` input 8: read data; valid when `mem_ready`=1.
- `mem_ready` input 1: beat accepted at an edge where `mem_rd`&&`mem_ready`.
- `icode`, `ifun`, `rA`, `rB` output 4 each: instruction fields.
- `valC` output 64: constant word, little-endian.
- `valP` output 64: `pc`+length.
- `done` output 1: one-cycle pulse when fields are valid.
- `busy` output 1: high in FETCH.
- `halt` output 1: halt fetched; sticky until reset.
- `instr_valid` output 1: 0 for icode > 4'hB.
- `imem_error` output 1: address out of range.

## Operation
- States: IDLE, FETCH, DONE, HALTED.
- IDLE: if `start`=1, capture `pc`=`pc_in`, clear beat count `k`=0, clear field registers, and go to FETCH. `start` outside IDLE is ignored.
- FETCH: drive `mem_addr`=`pc`+`k` and `mem_rd`=1. On an accepted beat, store the byte and increment `k`.
  - Byte 0: `icode`=[7:4], `ifun`=[3:0]. It sets length L.
  - icode 0, 1, 9: L=1.
  - icode 2, 6, A, B: L=2.
  - icode 3, 4, 5: L=10.
  - icode 7, 8: L=9.
  - icode > B: L=1 and `instr_valid`=0.
- Register byte (L=2 or 10, at k=1): `rA`=[7:4], `rB`=[3:0].
- Constant bytes: byte j lands in `valC`[8*(j-o)+:8], with o=2 for L=10 and o=1 for L=9.
- Absent fields: `rA`=`rB`=4'hF and `valC`=0.
- When `k` reaches L: compute `valP`=`pc`+L, using 64-bit wrap-around arithmetic. Then go to DONE.
- Range check: before issuing each beat, if `pc`+`k` > IMEM_SIZE-1, do not assert `mem_rd`. Instead set `imem_error`=1 and `valP`=`pc`+`k`, and go to DONE. Fields already captured remain; uncaptured fields hold their cleared values.
- DONE: `done`=1 for exactly one cycle. If `icode`=0, `instr_valid`=1 and `imem_error`=0, set `halt`=1 and go to HALTED; otherwise go to IDLE.
- HALTED: terminal; `start` is ignored and `mem_rd`=0 until reset.
- `mem_ready` low in FETCH: hold `mem_addr` and `mem_rd` stable and stall indefinitely. There is no timeout.

## Timing
- Reset (async, any state): state=IDLE, `k`=0.
  - Outputs 0: `mem_rd`, `mem_addr`, `icode`, `ifun`, `valC`, `valP`, `done`, `busy`, `halt`, `instr_valid`, `imem_error`.
  - Outputs 4'hF: `rA`, `rB`.
  - A fetch in progress is abandoned and no `done` is produced.
- Output fields are registered. They change only during FETCH and hold from DONE until the next accepted `start`.
- With `mem_ready` always 1: `start` sampled at edge 0, the L beats are accepted at edges 1..L, and `done` is high during the cycle after edge L+1. Latency is therefore L+2 edges from `start` to the `done` cycle.
- Each cycle of `mem_ready`=0 adds one cycle of latency.
- `busy`=1 from the edge after `start` until the edge that enters DONE.
- Earliest back-to-back: `start` may be asserted in the DONE cycle but is sampled only once back in IDLE (the cycle after DONE).

## Test plan
- `pc_in`=0, memory[0]=8'h10 (nop), ready=1 -> one beat at addr 0; `done` 3 edges after start; `icode`=1, `valP`=1, `rA`=`rB`=F, `valC`=0.
- memory[4..13]=30 F3 0A 00 00 00 00 00 00 00 (irmovq $10,%rbx), `pc_in`=4 -> 10 beats at addrs 4..13; `rA`=F, `rB`=3, `valC`=64'hA, `valP`=14.
- memory[0..8]=80 20 00.. (call 0x20), `mem_ready` low for 3 cycles on beat 4 -> `mem_addr` held at 4 for those cycles; `valC`=64'h20, `valP`=9; latency 14 edges.
- `pc_in`=120, icode 5 (10 bytes) -> beats at 120..127, no beat at 128; `imem_error`=1, `valP`=128, `done` pulses, state returns to IDLE.
- memory[0]=8'hC0 -> `instr_valid`=0, `valP`=1; memory[x]=8'h00 -> `halt`=1; a later `start` produces no `mem_rd`.
- `rst_n` low during beat 5 of a 10-byte fetch -> all outputs reset immediately; after release, a `start` at `pc_in`=0 fetches correctly.
